// File: rtl/axi_lite_timer.sv
// AXI4-Lite timer peripheral: prescaled 32-bit up-counter with compare match,
// one-shot / auto-reload modes, sticky MATCH flag and level interrupt.
module axi_lite_timer #(
  parameter int ADDR_WIDTH  = 5,
  parameter int PRESC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  irq
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] R_CTRL = 3'd0, R_PRESC = 3'd1, R_CMP = 3'd2,
                         R_COUNT = 3'd3, R_STATUS = 3'd4;

  logic                   aw_held, w_held;
  logic [2:0]             aw_idx;
  logic [31:0]            wdata_q;
  logic [3:0]             wstrb_q;
  logic                   en, auto_rld, irq_en, match;
  logic [PRESC_WIDTH-1:0] prescale, presc_cnt;
  logic [31:0]            compare, count;
  logic                   aw_hs, w_hs, ar_hs, wr_fire;
  logic                   wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
  logic                   tick, hit;
  logic [31:0]            rd_data;
  logic                   rd_err;
  logic                   unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Readies are forced low while reset is asserted so an aborted transfer
  // cannot complete a handshake.
  assign s_axi_awready = !rst && !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !rst && !w_held && !s_axi_bvalid;
  assign s_axi_arready = !rst && !s_axi_rvalid;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign wr_fire = aw_held && w_held;

  assign wr_ctrl   = wr_fire && aw_idx == R_CTRL;
  assign wr_presc  = wr_fire && aw_idx == R_PRESC;
  assign wr_cmp    = wr_fire && aw_idx == R_CMP;
  assign wr_count  = wr_fire && aw_idx == R_COUNT;
  assign wr_status = wr_fire && aw_idx == R_STATUS;

  assign tick = en && presc_cnt == prescale;
  assign hit  = tick && count == compare;
  assign irq  = match && irq_en;

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axi_awaddr[4:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_fire) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= (aw_idx <= R_STATUS) ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (s_axi_araddr[4:2])
      R_CTRL:   rd_data = {29'd0, irq_en, auto_rld, en};
      R_PRESC:  rd_data = 32'(prescale);
      R_CMP:    rd_data = compare;
      R_COUNT:  rd_data = count;
      R_STATUS: rd_data = {31'd0, match};
      default:  rd_err  = 1'b1;
    endcase
  end

  // Read data is sampled from register state before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en        <= 1'b0;
      auto_rld  <= 1'b0;
      irq_en    <= 1'b0;
      match     <= 1'b0;
      prescale  <= '0;
      presc_cnt <= '0;
      compare   <= '0;
      count     <= '0;
    end else begin
      if (!en || tick) presc_cnt <= '0;
      else             presc_cnt <= presc_cnt + PRESC_WIDTH'(1);

      if (wr_count)                 count <= merge(count, wdata_q, wstrb_q);
      else if (hit && auto_rld)     count <= '0;
      else if (tick && !hit)        count <= count + 32'd1;

      if (hit)                                       match <= 1'b1;
      else if (wr_status && wstrb_q[0] && wdata_q[0]) match <= 1'b0;

      if (wr_ctrl && wstrb_q[0]) {irq_en, auto_rld, en} <= wdata_q[2:0];
      // One-shot completion overrides a simultaneous software enable.
      if (hit && !auto_rld) en <= 1'b0;

      if (wr_presc) prescale <= PRESC_WIDTH'(merge(32'(prescale), wdata_q, wstrb_q));
      if (wr_cmp)   compare  <= merge(compare, wdata_q, wstrb_q);
    end
  end
endmodule

// File: tb/tb_axi_lite_timer.sv
// Bench for axi_lite_timer: register table plus timed sequences for counting,
// one-shot, wrap, handshake stalls and the W1C/match collision.
module tb_axi_lite_timer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        s_axi_awvalid = 0, s_axi_awready, s_axi_wvalid = 0, s_axi_wready;
  logic [4:0]  s_axi_awaddr = 0, s_axi_araddr = 0;
  logic [31:0] s_axi_wdata = 0, s_axi_rdata;
  logic [3:0]  s_axi_wstrb = 0;
  logic        s_axi_bvalid, s_axi_bready = 0, s_axi_arvalid = 0, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready = 0, irq;
  logic [1:0]  s_axi_bresp, s_axi_rresp;

  axi_lite_timer #(.ADDR_WIDTH(5), .PRESC_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .irq(irq));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  int last_fire_cyc = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endfunction

  typedef struct { string nm; logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t sbq[$];

  // Read scoreboard: one expected entry per accepted read, popped on R handshake.
  always @(negedge clk) begin
    if (s_axi_rvalid && s_axi_rready) begin
      check("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check({e.nm, "_data"}, s_axi_rdata, e.data);
        check({e.nm, "_resp"}, 32'(s_axi_rresp), 32'(e.resp));
      end
    end
  end

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] ed, input logic [1:0] er);
    exp_t e;
    int n;
    logic hs;
    e.nm = nm; e.data = ed; e.resp = er;
    sbq.push_back(e);
    @(posedge clk); #1;
    s_axi_arvalid = 1; s_axi_araddr = a;
    n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = s_axi_arready;
      @(posedge clk); #1; n++;
    end
    s_axi_arvalid = 0;
    check({nm, "_ar_done"}, 32'(hs), 32'd1);
    s_axi_rready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_rvalid && n < 50);
    check({nm, "_r_seen"}, 32'(s_axi_rvalid), 32'd1);
    @(posedge clk); #1;
    s_axi_rready = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp);
    int n;
    logic ah, wh;
    @(posedge clk); #1;
    s_axi_awvalid = 1; s_axi_awaddr = a;
    s_axi_wvalid = 1; s_axi_wdata = d; s_axi_wstrb = s;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
      @(negedge clk);
      ah = s_axi_awvalid && s_axi_awready;
      wh = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (ah) s_axi_awvalid = 0;
      if (wh) s_axi_wvalid = 0;
      n++;
    end
    check("wr_aw_w_done", 32'(s_axi_awvalid || s_axi_wvalid), 32'd0);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    s_axi_bready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 50);
    check("wr_b_seen", 32'(s_axi_bvalid), 32'd1);
    last_fire_cyc = cyc;
    resp = s_axi_bresp;
    @(posedge clk); #1;
    s_axi_bready = 0;
  endtask

  typedef struct {
    string nm; bit is_wr; logic [4:0] a; logic [31:0] d; logic [3:0] s;
    logic [31:0] ed; logic [1:0] er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input string nm, input bit is_wr, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] ed, input logic [1:0] er);
    vec_t v;
    v.nm = nm; v.is_wr = is_wr; v.a = a; v.d = d; v.s = s; v.ed = ed; v.er = er;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [1:0] r;
    int t0, t1, tm, n;
    logic [31:0] wrap_cmp [3];
    wrap_cmp[0] = 32'hFFFF_FFFF; wrap_cmp[1] = 32'h0; wrap_cmp[2] = 32'h1;

    add("rst_ctrl",   0, 5'h00, 0, 0, 32'h0, 2'b00);
    add("rst_presc",  0, 5'h04, 0, 0, 32'h0, 2'b00);
    add("rst_cmp",    0, 5'h08, 0, 0, 32'h0, 2'b00);
    add("rst_count",  0, 5'h0C, 0, 0, 32'h0, 2'b00);
    add("rst_status", 0, 5'h10, 0, 0, 32'h0, 2'b00);
    add("w_presc",    1, 5'h04, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
    add("presc_mask", 0, 5'h04, 0, 0, 32'h0000_FFFF, 2'b00);
    add("w_cmp",      1, 5'h08, 32'h1234_5678, 4'hF, 0, 2'b00);
    add("cmp_rb",     0, 5'h08, 0, 0, 32'h1234_5678, 2'b00);
    add("w_count",    1, 5'h0C, 32'hCAFE_F00D, 4'hF, 0, 2'b00);
    add("count_rb",   0, 5'h0C, 0, 0, 32'hCAFE_F00D, 2'b00);
    add("w_ctrl",     1, 5'h00, 32'hFFFF_FFF6, 4'hF, 0, 2'b00);
    add("ctrl_mask",  0, 5'h00, 0, 0, 32'h6, 2'b00);
    add("w_cmp_strb", 1, 5'h08, 32'hA5A5_A5A5, 4'h5, 0, 2'b00);
    add("cmp_strb",   0, 5'h08, 0, 0, 32'h12A5_56A5, 2'b00);
    add("rd_unmap18", 0, 5'h18, 0, 0, 32'h0, 2'b10);
    add("w_unmap18",  1, 5'h18, 32'hFFFF_FFFF, 4'hF, 0, 2'b10);
    add("w_unmap1c",  1, 5'h1C, 32'h1, 4'hF, 0, 2'b10);
    add("rd_unmap14", 0, 5'h14, 0, 0, 32'h0, 2'b10);
    add("ctrl_keep",  0, 5'h00, 0, 0, 32'h6, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    rst = 0;
    @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].a, tbl[i].d, tbl[i].s, r);
        check({tbl[i].nm, "_bresp"}, 32'(r), 32'(tbl[i].er));
      end else begin
        rd(tbl[i].nm, tbl[i].a, tbl[i].ed, tbl[i].er);
      end
    end

    // Auto-reload with prescale 3, compare 5: 6 ticks of 4 cycles per match.
    wr(5'h00, 0, 4'hF, r); wr(5'h04, 3, 4'hF, r); wr(5'h08, 5, 4'hF, r);
    wr(5'h0C, 0, 4'hF, r); wr(5'h10, 1, 4'hF, r);
    wr(5'h00, 32'h7, 4'hF, r);
    t0 = last_fire_cyc;
    n = 0;
    while (!irq && n < 200) begin @(negedge clk); n++; end
    t1 = cyc;
    check("irq_latency", 32'(t1 - t0), 32'd24);
    rd("count_reload", 5'h0C, 32'h0, 2'b00);
    wr(5'h10, 1, 4'h1, r);
    check("irq_cleared", 32'(irq), 32'd0);
    n = 0;
    while (!irq && n < 200) begin @(negedge clk); n++; end
    check("irq_period", 32'(cyc - t1), 32'd24);
    wr(5'h00, 0, 4'hF, r); wr(5'h10, 1, 4'hF, r);

    // One-shot with prescale 0.
    wr(5'h04, 0, 4'hF, r); wr(5'h08, 2, 4'hF, r); wr(5'h0C, 0, 4'hF, r);
    wr(5'h00, 32'h1, 4'hF, r);
    repeat (10) @(negedge clk);
    rd("oneshot_count", 5'h0C, 32'h2, 2'b00);
    rd("oneshot_ctrl", 5'h00, 32'h0, 2'b00);
    rd("oneshot_match", 5'h10, 32'h1, 2'b00);
    check("oneshot_irq_masked", 32'(irq), 32'd0);
    wr(5'h10, 1, 4'hF, r);
    rd("w1c_status", 5'h10, 32'h0, 2'b00);

    // Wrap: one-shot stops on compare, so the final COUNT proves the path taken.
    for (int k = 0; k < 3; k++) begin
      wr(5'h0C, 32'hFFFF_FFFE, 4'hF, r);
      wr(5'h08, wrap_cmp[k], 4'hF, r);
      wr(5'h00, 32'h1, 4'hF, r);
      repeat (8) @(negedge clk);
      rd($sformatf("wrap_count%0d", k), 5'h0C, wrap_cmp[k], 2'b00);
    end
    wr(5'h10, 1, 4'hF, r);

    // Handshake stalls: W leads AW by 3 cycles, bready held low for 4.
    wr(5'h08, 32'h1122_3344, 4'hF, r);
    @(posedge clk); #1;
    s_axi_wvalid = 1; s_axi_wdata = 32'hAABB_CCDD; s_axi_wstrb = 4'h2;
    @(negedge clk); check("hs_wready", 32'(s_axi_wready), 32'd1);
    @(posedge clk); #1; s_axi_wvalid = 0;
    @(negedge clk); check("hs_w_held", 32'(s_axi_wready), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    s_axi_awvalid = 1; s_axi_awaddr = 5'h08;
    @(negedge clk); check("hs_awready", 32'(s_axi_awready), 32'd1);
    @(posedge clk); #1; s_axi_awvalid = 0;
    @(posedge clk); #1;
    s_axi_awvalid = 1; s_axi_awaddr = 5'h0C;
    s_axi_wvalid = 1; s_axi_wdata = 32'h0000_DEAD; s_axi_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hs_bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      check("hs_aw_blocked", 32'(s_axi_awready), 32'd0);
      check("hs_w_blocked", 32'(s_axi_wready), 32'd0);
      @(posedge clk); #1;
    end
    check("hs_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1;
    @(posedge clk); #1; s_axi_bready = 0;
    @(negedge clk);
    check("hs_aw_reopen", 32'(s_axi_awready), 32'd1);
    check("hs_w_reopen", 32'(s_axi_wready), 32'd1);
    @(posedge clk); #1; s_axi_awvalid = 0; s_axi_wvalid = 0;
    s_axi_bready = 1; n = 0;
    do begin @(negedge clk); n++; end while (!s_axi_bvalid && n < 50);
    check("hs_b2_seen", 32'(s_axi_bvalid), 32'd1);
    @(posedge clk); #1; s_axi_bready = 0;
    rd("hs_cmp_byte1", 5'h08, 32'h1122_CC44, 2'b00);
    rd("hs_count", 5'h0C, 32'h0000_DEAD, 2'b00);

    // W1C lands on the same edge as a one-shot match: MATCH must survive.
    wr(5'h04, 15, 4'hF, r); wr(5'h08, 0, 4'hF, r); wr(5'h0C, 0, 4'hF, r);
    wr(5'h00, 32'h1, 4'hF, r);
    tm = last_fire_cyc + 16;
    while (cyc < tm - 3) @(negedge clk);
    wr(5'h10, 1, 4'hF, r);
    check("collide_align", 32'(last_fire_cyc), 32'(tm));
    rd("collide_match", 5'h10, 32'h1, 2'b00);

    // Reset during an outstanding read drops rvalid immediately.
    @(posedge clk); #1; s_axi_arvalid = 1; s_axi_araddr = 5'h00;
    @(posedge clk); #1; s_axi_arvalid = 0;
    check("abort_rvalid_pre", 32'(s_axi_rvalid), 32'd1);
    rst = 1; #1;
    check("abort_rvalid", 32'(s_axi_rvalid), 32'd0);
    @(posedge clk); #1; rst = 0;
    rd("abort_status", 5'h10, 32'h0, 2'b00);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
